// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
// Used by if_fetch_stage and if_skid_buf.
package mips_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  // Encodes sll $0,$0,0, so a bubble decodes as a harmless no-op.
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HOLD,
    HOLD_SKID
  } if_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that holds the fetched word arriving while decode is stalled.
// Clear has priority over write, and write has priority over read.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic               clr_i,
  input  logic               rd_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               full_o
);

  logic [INSTR_W-1:0] data_q;
  logic [PC_W-1:0]    pc_q;
  logic               full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= NOP_WORD;
      pc_q   <= '0;
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (wr_i) begin
      data_q <= data_i;
      pc_q   <= pc_i;
      full_q <= 1'b1;
    end else if (rd_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;
  assign full_o = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address, tracks the in-flight request,
// and owns the IF/ID register. The optional stall counter port is enabled by IF_STALL_CNT_EN.
module if_fetch_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_i,
  output logic               pc_en_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt_o
`endif
);

  if_state_t          state_q, state_d;
  logic               req_v_q, req_v_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  if_id_t             if_id_q, if_id_d;

  logic               skid_wr, skid_clr, skid_rd, skid_full;
  logic [INSTR_W-1:0] skid_data;
  logic [PC_W-1:0]    skid_pc;

  assign pc_en_o     = ~stall_i;
  assign imem_addr_o = pc_i;

  if_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (skid_wr),
    .clr_i  (skid_clr),
    .rd_i   (skid_rd),
    .data_i (imem_data_i),
    .pc_i   (req_pc_q),
    .data_o (skid_data),
    .pc_o   (skid_pc),
    .full_o (skid_full)
  );

  always_comb begin
    state_d  = state_q;
    if_id_d  = if_id_q;
    req_v_d  = ~stall_i & ~flush_i;
    req_pc_d = pc_i;
    skid_wr  = 1'b0;
    skid_clr = 1'b0;
    skid_rd  = 1'b0;

    if (flush_i) begin
      if_id_d  = '{instr: NOP_WORD, pc: '0, valid: 1'b0};
      skid_clr = 1'b1;
      state_d  = RUN;
    end else if (stall_i) begin
      // The word already requested still returns this cycle; park it.
      skid_wr = req_v_q;
      state_d = (req_v_q || skid_full) ? HOLD_SKID : HOLD;
    end else begin
      state_d = RUN;
      if (state_q == HOLD_SKID) begin
        if_id_d = '{instr: skid_data, pc: skid_pc, valid: 1'b1};
        skid_rd = 1'b1;
      end else if (req_v_q) begin
        if_id_d = '{instr: imem_data_i, pc: req_pc_q, valid: 1'b1};
      end else begin
        if_id_d = '{instr: NOP_WORD, pc: '0, valid: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
      if_id_q  <= '{instr: NOP_WORD, pc: '0, valid: 1'b0};
    end else begin
      state_q  <= state_d;
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
      if_id_q  <= if_id_d;
    end
  end

  assign instr_o = if_id_q.valid ? if_id_q.instr : NOP_WORD;
  assign pc_o    = if_id_q.pc;
  assign valid_o = if_id_q.valid;

`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_i && !flush_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: per-cycle vector table plus an in-order instruction scoreboard.
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [PC_W-1:0]    pc_i;
  logic               pc_en_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic               stall_i;
  logic               flush_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    pc_o;
  logic               valid_o;
`ifdef IF_STALL_CNT_EN
  logic [15:0]        stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .pc_en_o     (pc_en_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_i (imem_data_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: mem[k] = A000_0000 + k, one cycle read latency.
  always @(posedge clk) imem_data_i <= 32'hA000_0000 + {22'd0, imem_addr_o};

  typedef struct {
    logic            stall;
    logic            flush;
    logic [PC_W-1:0] pc;
    logic            exp_valid;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  vec_t tbl[28];
  logic [PC_W-1:0] sb_q[$];

  function automatic logic [31:0] word_of(input logic [PC_W-1:0] p);
    return 32'hA000_0000 + {22'd0, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic s, input logic f, input logic [PC_W-1:0] p,
                         input logic ev, input logic [PC_W-1:0] ep);
    tbl[i].stall = s; tbl[i].flush = f; tbl[i].pc = p;
    tbl[i].exp_valid = ev; tbl[i].exp_pc = ep;
  endtask

  // Entered just after a posedge (or reset release); leaves just after the next posedge.
  task automatic run_row(input int i);
    logic [PC_W-1:0] exp_sb;
    stall_i = tbl[i].stall;
    flush_i = tbl[i].flush;
    pc_i    = tbl[i].pc;
    @(negedge clk);
    chk($sformatf("row%0d valid", i), {31'd0, valid_o}, {31'd0, tbl[i].exp_valid});
    chk($sformatf("row%0d pc_en", i), {31'd0, pc_en_o}, {31'd0, ~tbl[i].stall});
    chk($sformatf("row%0d imem_addr", i), {22'd0, imem_addr_o}, {22'd0, tbl[i].pc});
    if (tbl[i].exp_valid) begin
      chk($sformatf("row%0d pc", i), {22'd0, pc_o}, {22'd0, tbl[i].exp_pc});
      chk($sformatf("row%0d instr", i), instr_o, word_of(tbl[i].exp_pc));
    end else begin
      chk($sformatf("row%0d instr_nop", i), instr_o, NOP_WORD);
    end
    // Decode consumes IF/ID when not stalled; every fetched PC must appear once, in order.
    if (!stall_i && valid_o) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_row%0d unexpected pc=%h required=none", i, pc_o);
      end else begin
        exp_sb = sb_q.pop_front();
        chk($sformatf("sb_row%0d pc", i), {22'd0, pc_o}, {22'd0, exp_sb});
        chk($sformatf("sb_row%0d instr", i), instr_o, word_of(exp_sb));
      end
    end
    if (flush_i) sb_q.delete();
    if (!stall_i && !flush_i) sb_q.push_back(pc_i);
    @(posedge clk); #1;
  endtask

  initial begin
    set_row( 0, 0, 0, 10'h000, 0, 10'h000);
    set_row( 1, 0, 0, 10'h001, 0, 10'h000);
    set_row( 2, 0, 0, 10'h002, 1, 10'h000);
    set_row( 3, 0, 0, 10'h003, 1, 10'h001);
    set_row( 4, 0, 0, 10'h004, 1, 10'h002);
    set_row( 5, 0, 0, 10'h005, 1, 10'h003);
    set_row( 6, 1, 0, 10'h006, 1, 10'h004);
    set_row( 7, 1, 0, 10'h006, 1, 10'h004);
    set_row( 8, 1, 0, 10'h006, 1, 10'h004);
    set_row( 9, 0, 0, 10'h006, 1, 10'h004);
    set_row(10, 0, 0, 10'h007, 1, 10'h005);
    set_row(11, 0, 1, 10'h008, 1, 10'h006);
    set_row(12, 0, 0, 10'h100, 0, 10'h000);
    set_row(13, 0, 0, 10'h101, 0, 10'h000);
    set_row(14, 0, 0, 10'h102, 1, 10'h100);
    set_row(15, 0, 0, 10'h103, 1, 10'h101);
    set_row(16, 1, 0, 10'h104, 1, 10'h102);
    set_row(17, 1, 0, 10'h104, 1, 10'h102);
    set_row(18, 1, 1, 10'h104, 1, 10'h102);
    set_row(19, 1, 0, 10'h200, 0, 10'h000);
    set_row(20, 0, 0, 10'h200, 0, 10'h000);
    set_row(21, 0, 0, 10'h201, 0, 10'h000);
    set_row(22, 0, 0, 10'h202, 1, 10'h200);
    set_row(23, 0, 0, 10'h3FE, 1, 10'h201);
    set_row(24, 0, 0, 10'h3FF, 1, 10'h202);
    set_row(25, 0, 0, 10'h000, 1, 10'h3FE);
    set_row(26, 0, 0, 10'h001, 1, 10'h3FF);
    set_row(27, 0, 0, 10'h002, 1, 10'h000);

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; pc_i = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset valid", {31'd0, valid_o}, 32'd0);
    chk("reset pc", {22'd0, pc_o}, 32'd0);
    chk("reset instr", instr_o, NOP_WORD);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) run_row(i);

`ifdef IF_STALL_CNT_EN
    // Stalled rows without flush: 6,7,8,16,17,19.
    chk("stall_cnt table", {16'd0, stall_cnt_o}, 32'd6);
`endif

    // Async reset between edges while stalled with a valid word held.
    stall_i = 1'b1; pc_i = 10'h003;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre-reset valid", {31'd0, valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midstall reset valid", {31'd0, valid_o}, 32'd0);
    chk("midstall reset pc", {22'd0, pc_o}, 32'd0);
    chk("midstall reset instr", instr_o, NOP_WORD);
`ifdef IF_STALL_CNT_EN
    chk("midstall reset stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 6; i++) run_row(i);

`ifdef IF_STALL_CNT_EN
    stall_i = 1'b1; flush_i = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_cnt saturate", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
    stall_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
